// File: rtl/pipe_stage_chain_if.sv
// Handshake bundle between a producer, the pipe_stage_chain and its consumer.
// The chain itself takes the slave view; the surrounding stages take the master view.
interface pipe_stage_chain_if #(
  parameter int DATA_W = 64,
  parameter int STAGES = 4
);
  localparam int OCC_W = $clog2(STAGES + 1);

  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic              ready_o;
  logic [STAGES-1:0] kill_i;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic              ready_i;
  logic [OCC_W-1:0]  occupancy_o;

  modport master (
    output valid_i, data_i, kill_i, ready_i,
    input  ready_o, valid_o, data_o, occupancy_o
  );

  modport slave (
    input  valid_i, data_i, kill_i, ready_i,
    output ready_o, valid_o, data_o, occupancy_o
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// Chain of valid-tagged pipeline registers with downstream back-pressure and per-stage kill.
// COLLAPSE=1 lets bubbles be squeezed out under stall; COLLAPSE=0 stalls every stage together.
module pipe_stage_chain #(
  parameter int DATA_W   = 64,
  parameter int STAGES   = 4,
  parameter int COLLAPSE = 1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  pipe_stage_chain_if.slave   bus
);
  localparam int OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0]             v;
  logic [STAGES-1:0]             adv;
  logic [STAGES-1:0]             in_v;
  logic [STAGES-1:0][DATA_W-1:0] d;
  logic [OCC_W-1:0]              occ;

  // A stage may advance when it, or any stage ahead of it, is empty, or the consumer takes.
  // Written as a reduction over the upper slice so no signal feeds back on itself.
  if (COLLAPSE != 0) begin : g_collapse
    for (genvar k = 0; k < STAGES; k++) begin : g_adv
      assign adv[k] = bus.ready_i | ~(&v[STAGES-1:k]);
    end
  end else begin : g_lockstep
    assign adv = {STAGES{bus.ready_i | ~v[STAGES-1]}};
  end

  assign in_v[0] = bus.valid_i;
  for (genvar k = 1; k < STAGES; k++) begin : g_in
    assign in_v[k] = v[k-1] & ~bus.kill_i[k-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // pre-edge value of its neighbour; blocking here would ripple one entry through all stages.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) v[k] <= in_v[k];
        else        v[k] <= v[k] & ~bus.kill_i[k];
      end
    end
  end

  // NOTE: payload registers are reset too, because data_o must read zero out of reset;
  // without that requirement they could be left unreset and qualified by v alone.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      d <= '0;
    end else begin
      if (adv[0] && in_v[0]) d[0] <= bus.data_i;
      for (int k = 1; k < STAGES; k++) begin
        if (adv[k] && in_v[k]) d[k] <= d[k-1];
      end
    end
  end

  // NOTE: combinational blocks assign a default before any conditional logic, so no
  // path leaves the variable unassigned and no latch is inferred.
  always_comb begin
    occ = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ = occ + OCC_W'(v[k]);
    end
  end

  assign bus.ready_o     = adv[0];
  assign bus.valid_o     = v[STAGES-1] & ~bus.kill_i[STAGES-1];
  assign bus.data_o      = d[STAGES-1];
  assign bus.occupancy_o = occ;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: one bubble-collapsing and one lockstep instance,
// each scenario task drives stimulus and compares against hand-derived cycle expectations.
module tb_pipe_stage_chain;
  localparam int DATA_W = 64;
  localparam int STAGES = 4;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  pipe_stage_chain_if #(.DATA_W(DATA_W), .STAGES(STAGES)) c1_if ();
  pipe_stage_chain_if #(.DATA_W(DATA_W), .STAGES(STAGES)) c0_if ();

  pipe_stage_chain #(.DATA_W(DATA_W), .STAGES(STAGES), .COLLAPSE(1)) u_c1 (
    .clk_i (clk), .rstn_i(rstn), .bus(c1_if.slave)
  );
  pipe_stage_chain #(.DATA_W(DATA_W), .STAGES(STAGES), .COLLAPSE(0)) u_c0 (
    .clk_i (clk), .rstn_i(rstn), .bus(c0_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Each cycle: step 1 ns past the rising edge, drive inputs, settle 1 ns, then sample.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    c1_if.valid_i = 1'b0; c1_if.data_i = '0; c1_if.kill_i = '0; c1_if.ready_i = 1'b1;
    c0_if.valid_i = 1'b0; c0_if.data_i = '0; c0_if.kill_i = '0; c0_if.ready_i = 1'b1;
  endtask

  task automatic drain();
    set_idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      if (c1_if.occupancy_o == 0 && c0_if.occupancy_o == 0) break;
    end
    checks++;
    if (c1_if.occupancy_o !== 3'd0 || c0_if.occupancy_o !== 3'd0) begin
      failures++;
      $display("FAIL drain: occupancy c1=%0d c0=%0d required 0", c1_if.occupancy_o, c0_if.occupancy_o);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    set_idle();
    #3;
    checks++; if (c1_if.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", c1_if.valid_o); end
    checks++; if (c1_if.data_o !== 64'd0) begin failures++; $display("FAIL reset_data: got %h want 0", c1_if.data_o); end
    checks++; if (c1_if.occupancy_o !== 3'd0) begin failures++; $display("FAIL reset_occ: got %0d want 0", c1_if.occupancy_o); end
    checks++; if (c1_if.ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready_c1: got %b want 1", c1_if.ready_o); end
    checks++; if (c0_if.ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready_c0: got %b want 1", c0_if.ready_o); end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    checks++; if (c1_if.valid_o !== 1'b0 || c0_if.valid_o !== 1'b0) begin failures++; $display("FAIL post_reset_valid: got c1=%b c0=%b want 0", c1_if.valid_o, c0_if.valid_o); end
    checks++; if (c1_if.ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b want 1", c1_if.ready_o); end
  endtask

  // Full-rate stream 0x1..0x8: first output at cycle 4, one per cycle after that.
  task automatic test_stream();
    logic exp_v;
    for (int c = 0; c < 12; c++) begin
      tick();
      c1_if.ready_i = 1'b1;
      c1_if.valid_i = (c < 8);
      c1_if.data_i  = 64'(c + 1);
      #1;
      exp_v = (c >= 4);
      checks++; if (c1_if.valid_o !== exp_v) begin failures++; $display("FAIL stream_valid c%0d: got %b want %b", c, c1_if.valid_o, exp_v); end
      if (exp_v) begin
        checks++; if (c1_if.data_o !== 64'(c - 3)) begin failures++; $display("FAIL stream_data c%0d: got %h want %h", c, c1_if.data_o, 64'(c - 3)); end
      end
      checks++; if (c1_if.ready_o !== 1'b1) begin failures++; $display("FAIL stream_ready c%0d: got %b want 1", c, c1_if.ready_o); end
      if (c >= 4 && c <= 7) begin
        checks++; if (c1_if.occupancy_o !== 3'd4) begin failures++; $display("FAIL stream_occ c%0d: got %0d want 4", c, c1_if.occupancy_o); end
      end
    end
    drain();
  endtask

  // Stalled consumer: entries compact to the output, ready_o holds while a bubble exists.
  task automatic test_collapse();
    for (int c = 0; c < 15; c++) begin
      tick();
      c1_if.ready_i = (c >= 10);
      c1_if.valid_i = (c == 0 || c == 1 || c == 7 || c == 8 || c == 9);
      case (c)
        0:       c1_if.data_i = 64'hA;
        1:       c1_if.data_i = 64'hB;
        7:       c1_if.data_i = 64'hC;
        8:       c1_if.data_i = 64'hD;
        9:       c1_if.data_i = 64'hE;
        default: c1_if.data_i = '0;
      endcase
      #1;
      if (c >= 4 && c <= 6) begin
        checks++; if (c1_if.valid_o !== 1'b1 || c1_if.data_o !== 64'hA) begin failures++; $display("FAIL collapse_hold c%0d: got v=%b d=%h want v=1 d=a", c, c1_if.valid_o, c1_if.data_o); end
        checks++; if (c1_if.occupancy_o !== 3'd2) begin failures++; $display("FAIL collapse_occ2 c%0d: got %0d want 2", c, c1_if.occupancy_o); end
        checks++; if (c1_if.ready_o !== 1'b1) begin failures++; $display("FAIL collapse_ready_bubble c%0d: got %b want 1", c, c1_if.ready_o); end
      end
      if (c == 8) begin
        checks++; if (c1_if.ready_o !== 1'b1 || c1_if.occupancy_o !== 3'd3) begin failures++; $display("FAIL collapse_c8: got ready=%b occ=%0d want ready=1 occ=3", c1_if.ready_o, c1_if.occupancy_o); end
      end
      if (c == 9) begin
        checks++; if (c1_if.occupancy_o !== 3'd4) begin failures++; $display("FAIL collapse_full_occ: got %0d want 4", c1_if.occupancy_o); end
        checks++; if (c1_if.ready_o !== 1'b0) begin failures++; $display("FAIL collapse_full_ready: got %b want 0", c1_if.ready_o); end
        checks++; if (c1_if.data_o !== 64'hA) begin failures++; $display("FAIL collapse_full_data: got %h want a", c1_if.data_o); end
      end
      if (c == 10) begin
        checks++; if (c1_if.ready_o !== 1'b1) begin failures++; $display("FAIL collapse_full_release_ready: got %b want 1", c1_if.ready_o); end
        checks++; if (c1_if.valid_o !== 1'b1 || c1_if.data_o !== 64'hA) begin failures++; $display("FAIL collapse_out_a: got v=%b d=%h want v=1 d=a", c1_if.valid_o, c1_if.data_o); end
      end
      if (c >= 11 && c <= 13) begin
        checks++; if (c1_if.valid_o !== 1'b1 || c1_if.data_o !== 64'(c)) begin failures++; $display("FAIL collapse_order c%0d: got v=%b d=%h want v=1 d=%h", c, c1_if.valid_o, c1_if.data_o, 64'(c)); end
      end
      if (c == 14) begin
        checks++; if (c1_if.valid_o !== 1'b0) begin failures++; $display("FAIL collapse_no_extra: got %b want 0", c1_if.valid_o); end
      end
    end
    drain();
  endtask

  // Lockstep: a single live entry at the output with ready_i=0 blocks input despite bubbles.
  task automatic test_lockstep();
    for (int c = 0; c < 16; c++) begin
      tick();
      c0_if.ready_i = !(c >= 4 && c <= 13);
      c0_if.valid_i = (c == 0) || (c >= 4 && c <= 13);
      c0_if.data_i  = (c == 0) ? 64'hC : 64'hEE;
      #1;
      if (c >= 4 && c <= 13) begin
        checks++; if (c0_if.ready_o !== 1'b0) begin failures++; $display("FAIL lockstep_ready c%0d: got %b want 0", c, c0_if.ready_o); end
        checks++; if (c0_if.valid_o !== 1'b1 || c0_if.data_o !== 64'hC) begin failures++; $display("FAIL lockstep_hold c%0d: got v=%b d=%h want v=1 d=c", c, c0_if.valid_o, c0_if.data_o); end
        checks++; if (c0_if.occupancy_o !== 3'd1) begin failures++; $display("FAIL lockstep_occ c%0d: got %0d want 1", c, c0_if.occupancy_o); end
      end
      if (c == 14) begin
        checks++; if (c0_if.valid_o !== 1'b1 || c0_if.data_o !== 64'hC || c0_if.ready_o !== 1'b1) begin failures++; $display("FAIL lockstep_release: got v=%b d=%h ready=%b want v=1 d=c ready=1", c0_if.valid_o, c0_if.data_o, c0_if.ready_o); end
      end
      if (c == 15) begin
        checks++; if (c0_if.valid_o !== 1'b0 || c0_if.occupancy_o !== 3'd0) begin failures++; $display("FAIL lockstep_empty: got v=%b occ=%0d want v=0 occ=0", c0_if.valid_o, c0_if.occupancy_o); end
      end
    end
    drain();
  endtask

  // Kill stages 0,1 mid-stream: entries 5 and 6 vanish, leaving a two-cycle gap.
  task automatic test_kill_stream();
    logic exp_v;
    for (int c = 0; c < 14; c++) begin
      tick();
      c1_if.ready_i = 1'b1;
      c1_if.valid_i = (c < 10);
      c1_if.data_i  = 64'(c + 1);
      c1_if.kill_i  = (c == 6) ? 4'b0011 : 4'b0000;
      #1;
      exp_v = (c >= 4) && (c - 3 != 5) && (c - 3 != 6);
      checks++; if (c1_if.valid_o !== exp_v) begin failures++; $display("FAIL kill_stream_valid c%0d: got %b want %b", c, c1_if.valid_o, exp_v); end
      if (exp_v) begin
        checks++; if (c1_if.data_o !== 64'(c - 3)) begin failures++; $display("FAIL kill_stream_data c%0d: got %h want %h", c, c1_if.data_o, 64'(c - 3)); end
      end
      if (c == 6) begin
        checks++; if (c1_if.occupancy_o !== 3'd4) begin failures++; $display("FAIL kill_stream_occ_before: got %0d want 4", c1_if.occupancy_o); end
      end
      if (c == 7) begin
        checks++; if (c1_if.occupancy_o !== 3'd2) begin failures++; $display("FAIL kill_stream_occ_after: got %0d want 2", c1_if.occupancy_o); end
      end
    end
    drain();
  endtask

  // Full and stalled, kill the output stage: masked immediately, refilled from stage 2.
  task automatic test_kill_stall();
    for (int c = 0; c < 12; c++) begin
      tick();
      c1_if.ready_i = (c >= 8);
      c1_if.valid_i = (c < 4);
      c1_if.data_i  = 64'(8'h11 * (c + 1));
      c1_if.kill_i  = (c == 5) ? 4'b1000 : 4'b0000;
      #1;
      if (c == 4) begin
        checks++; if (c1_if.occupancy_o !== 3'd4 || c1_if.ready_o !== 1'b0) begin failures++; $display("FAIL kill_stall_full: got occ=%0d ready=%b want occ=4 ready=0", c1_if.occupancy_o, c1_if.ready_o); end
        checks++; if (c1_if.valid_o !== 1'b1 || c1_if.data_o !== 64'h11) begin failures++; $display("FAIL kill_stall_head: got v=%b d=%h want v=1 d=11", c1_if.valid_o, c1_if.data_o); end
      end
      if (c == 5) begin
        checks++; if (c1_if.valid_o !== 1'b0) begin failures++; $display("FAIL kill_stall_mask: got %b want 0", c1_if.valid_o); end
        checks++; if (c1_if.occupancy_o !== 3'd4 || c1_if.ready_o !== 1'b0) begin failures++; $display("FAIL kill_stall_prekill: got occ=%0d ready=%b want occ=4 ready=0", c1_if.occupancy_o, c1_if.ready_o); end
      end
      if (c == 6) begin
        checks++; if (c1_if.valid_o !== 1'b0 || c1_if.occupancy_o !== 3'd3 || c1_if.ready_o !== 1'b1) begin failures++; $display("FAIL kill_stall_cleared: got v=%b occ=%0d ready=%b want v=0 occ=3 ready=1", c1_if.valid_o, c1_if.occupancy_o, c1_if.ready_o); end
      end
      if (c == 7) begin
        checks++; if (c1_if.valid_o !== 1'b1 || c1_if.data_o !== 64'h22) begin failures++; $display("FAIL kill_stall_refill: got v=%b d=%h want v=1 d=22", c1_if.valid_o, c1_if.data_o); end
      end
      if (c >= 8 && c <= 10) begin
        checks++; if (c1_if.valid_o !== 1'b1 || c1_if.data_o !== 64'(8'h11 * (c - 6))) begin failures++; $display("FAIL kill_stall_order c%0d: got v=%b d=%h want v=1 d=%h", c, c1_if.valid_o, c1_if.data_o, 64'(8'h11 * (c - 6))); end
      end
      if (c == 11) begin
        checks++; if (c1_if.valid_o !== 1'b0) begin failures++; $display("FAIL kill_stall_end: got %b want 0", c1_if.valid_o); end
      end
    end
    drain();
  endtask

  // Reset pulse mid-stream: outputs clear asynchronously, restart latency is 4 cycles.
  task automatic test_reset_mid();
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 6) rstn = 1'b1;
      c1_if.ready_i = 1'b1;
      c1_if.valid_i = 1'b1;
      c1_if.data_i  = 64'h100 + 64'(c);
      #1;
      if (c == 5) begin
        checks++; if (c1_if.valid_o !== 1'b1 || c1_if.data_o !== 64'h101) begin failures++; $display("FAIL reset_mid_pre: got v=%b d=%h want v=1 d=101", c1_if.valid_o, c1_if.data_o); end
        rstn = 1'b0;
        #1;
        checks++; if (c1_if.valid_o !== 1'b0 || c1_if.occupancy_o !== 3'd0) begin failures++; $display("FAIL reset_mid_async: got v=%b occ=%0d want v=0 occ=0", c1_if.valid_o, c1_if.occupancy_o); end
        checks++; if (c1_if.data_o !== 64'd0 || c1_if.ready_o !== 1'b1) begin failures++; $display("FAIL reset_mid_data: got d=%h ready=%b want d=0 ready=1", c1_if.data_o, c1_if.ready_o); end
      end
      if (c >= 6 && c <= 9) begin
        checks++; if (c1_if.valid_o !== 1'b0) begin failures++; $display("FAIL reset_mid_quiet c%0d: got %b want 0", c, c1_if.valid_o); end
      end
      if (c >= 10) begin
        checks++; if (c1_if.valid_o !== 1'b1 || c1_if.data_o !== 64'h100 + 64'(c - 4)) begin failures++; $display("FAIL reset_mid_restart c%0d: got v=%b d=%h want v=1 d=%h", c, c1_if.valid_o, c1_if.data_o, 64'h100 + 64'(c - 4)); end
      end
    end
    drain();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_collapse();
    test_lockstep();
    test_kill_stream();
    test_kill_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
